// File: rtl/pkt_stream_unpacker.sv
// -----------------------------------------------------------------------------
// pkt_stream_unpacker
//
// Receive-side deframer for the packer's byte stream. Bytes arrive one per
// handshake in wire order: header, len, payload[0..len-1], crc. Each packet is
// rebuilt into a parallel record. The record carries a checksum verdict and is
// held for a downstream consumer. Saturating good/error counters give status.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid && ready are both high. A producer holds valid and its data
// stable until that edge. Ready may depend on the receiver's state but never
// on the valid it is paired with, so there is no combinational loop.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   s_valid      input byte valid
//   s_ready      unpacker can take a byte (low only while a record is held,
//                and low while reset_n is low)
//   s_data       input stream byte
//   pkt_valid    reassembled record available
//   pkt_ready    consumer accepts the record
//   pkt_header   header byte of the record
//   pkt_len      payload length of the record
//   pkt_payload  payload; byte i at [8i+7:8i]; bytes at or beyond len are zero
//   pkt_crc_ok   received crc equals XOR of header, len and payload
//   good_cnt     records delivered with crc_ok=1 (saturating)
//   err_cnt      records delivered with crc_ok=0 plus dropped oversize
//                packets (saturating)
//   state_dbg    current FSM state, for observation only
// -----------------------------------------------------------------------------
module pkt_stream_unpacker #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [7:0]             pkt_header,
    output logic [7:0]             pkt_len,
    output logic [MAX_LEN*8-1:0]   pkt_payload,
    output logic                   pkt_crc_ok,
    output logic [CNT_W-1:0]       good_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LEN  = 3'd1,
        S_PAY  = 3'd2,
        S_CRC  = 3'd3,
        S_OUT  = 3'd4,
        S_DROP = 3'd5
    } state_t;

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state;
    logic [7:0] acc;        // running XOR checksum
    logic [7:0] idx;        // next payload slot in PAY
    logic [7:0] remaining;  // payload bytes still to discard in DROP
    logic [7:0] pay_mem [MAX_LEN];

    logic s_fire;

    // Ready is decoded from the state so the first cycle after reset release
    // already accepts a byte. Gating with reset_n keeps it low while in reset.
    assign s_ready   = reset_n && (state != S_OUT);
    assign s_fire    = s_valid && s_ready;
    assign state_dbg = state;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_payload
        assign pkt_payload[g*8 +: 8] = pay_mem[g];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HDR;
            acc        <= 8'd0;
            idx        <= 8'd0;
            remaining  <= 8'd0;
            pkt_valid  <= 1'b0;
            pkt_header <= 8'd0;
            pkt_len    <= 8'd0;
            pkt_crc_ok <= 1'b0;
            good_cnt   <= '0;
            err_cnt    <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                pay_mem[i] <= 8'd0;
            end
        end else begin
            case (state)
                S_HDR: begin
                    if (s_fire) begin
                        pkt_header <= s_data;
                        pkt_len    <= 8'd0;
                        pkt_crc_ok <= 1'b0;
                        acc        <= s_data;
                        // Clearing here keeps bytes beyond len at zero in the
                        // next record without a separate masking step.
                        for (int i = 0; i < MAX_LEN; i++) begin
                            pay_mem[i] <= 8'd0;
                        end
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (s_fire) begin
                        pkt_len <= s_data;
                        acc     <= acc ^ s_data;
                        idx     <= 8'd0;
                        if (s_data == 8'd0) begin
                            state <= S_CRC;
                        end else if (s_data > MAX_LEN_B) begin
                            // Too long to store: discard len payload bytes
                            // plus the crc byte.
                            remaining <= s_data;
                            state     <= S_DROP;
                        end else begin
                            state <= S_PAY;
                        end
                    end
                end

                S_PAY: begin
                    if (s_fire) begin
                        // Decoded write avoids indexing the array with a
                        // wider-than-needed index.
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 8'(i)) begin
                                pay_mem[i] <= s_data;
                            end
                        end
                        acc <= acc ^ s_data;
                        if (idx == pkt_len - 8'd1) begin
                            state <= S_CRC;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end

                S_CRC: begin
                    if (s_fire) begin
                        pkt_crc_ok <= (s_data == acc);
                        pkt_valid  <= 1'b1;
                        state      <= S_OUT;
                    end
                end

                S_OUT: begin
                    // Record fields are only written in the parsing states,
                    // so they are stable for the whole time pkt_valid is high.
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        state     <= S_HDR;
                        if (pkt_crc_ok) begin
                            if (good_cnt != CNT_MAX) begin
                                good_cnt <= good_cnt + CNT_W'(1);
                            end
                        end else begin
                            if (err_cnt != CNT_MAX) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                S_DROP: begin
                    if (s_fire) begin
                        // When remaining is zero, this byte is the crc.
                        if (remaining == 8'd0) begin
                            if (err_cnt != CNT_MAX) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                            state <= S_HDR;
                        end else begin
                            remaining <= remaining - 8'd1;
                        end
                    end
                end

                default: begin
                    state     <= S_HDR;
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stream_unpacker.sv
// -----------------------------------------------------------------------------
// Testbench for pkt_stream_unpacker.
// Inputs change on the falling edge, and pkt_ready changes just after the
// rising edge. A monitor samples record transfers on the falling edge. Each
// issued packet pushes its expected record, built from the byte list with
// plain XOR arithmetic, into exp_q. The monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pkt_stream_unpacker;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 16;
    localparam int REC_W   = 8 + 8 + 1 + MAX_LEN*8;

    logic                 clock;
    logic                 reset_n;
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           s_data;
    logic                 pkt_valid;
    logic                 pkt_ready = 1'b1;
    logic [7:0]           pkt_header;
    logic [7:0]           pkt_len;
    logic [MAX_LEN*8-1:0] pkt_payload;
    logic                 pkt_crc_ok;
    logic [CNT_W-1:0]     good_cnt;
    logic [CNT_W-1:0]     err_cnt;
    logic [2:0]           state_dbg;

    pkt_stream_unpacker #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_header  (pkt_header),
        .pkt_len     (pkt_len),
        .pkt_payload (pkt_payload),
        .pkt_crc_ok  (pkt_crc_ok),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] exp_rec;
    logic [REC_W-1:0] act_rec;
    int n_vec     = 0;
    int n_err     = 0;
    int stall_cnt = 0;
    int exp_good  = 0;
    int exp_err   = 0;
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;
    logic [7:0] pay_buf [256];

    // Single owner of pkt_ready: forced level or random backpressure.
    always @(posedge clock) begin
        #2;
        pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    function automatic int sat(input int v);
        int lim;
        lim = (1 << CNT_W) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset_n && pkt_valid && pkt_ready) begin
            n_vec++;
            act_rec = {pkt_header, pkt_len, pkt_crc_ok, pkt_payload};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL record: unexpected record %h at %0t", act_rec, $time);
            end else begin
                exp_rec = exp_q.pop_front();
                if (act_rec !== exp_rec) begin
                    n_err++;
                    $display("FAIL record: got %h expected %h at %0t", act_rec, exp_rec, $time);
                end
                if (exp_rec[MAX_LEN*8]) exp_good++;
                else                    exp_err++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called between a falling edge and the next rising edge. Returns at the
    // falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int budget;
        bit took;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        s_valid = 1'b1;
        s_data  = b;
        budget  = 0;
        forever begin
            took = s_ready;
            @(negedge clock);
            if (took) break;
            stall_cnt++;
            budget++;
            if (budget > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL s_ready_timeout: byte %h not accepted after %0d cycles", b, budget);
                break;
            end
        end
    endtask

    // Sends one packet. Payload comes from pay_buf (randomised first if rnd).
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] len,
                               input bit bad, input int gap_max, input bit rnd);
        logic [7:0]           x;
        logic [MAX_LEN*8-1:0] pv;
        int                   st0;
        if (rnd) begin
            for (int i = 0; i < int'(len); i++) pay_buf[i] = 8'($urandom_range(0, 255));
        end
        x  = hdr ^ len;
        pv = '0;
        for (int i = 0; i < int'(len); i++) begin
            x = x ^ pay_buf[i];
            if (i < MAX_LEN) pv[i*8 +: 8] = pay_buf[i];
        end
        if (int'(len) <= MAX_LEN) exp_q.push_back({hdr, len, ~bad, pv});
        else                      exp_err++;
        send_byte(hdr, gap_max);
        st0 = stall_cnt;
        send_byte(len, gap_max);
        for (int i = 0; i < int'(len); i++) send_byte(pay_buf[i], gap_max);
        send_byte(bad ? (x ^ 8'h01) : x, gap_max);
        if (int'(len) <= MAX_LEN) begin
            chk("latency_valid", 32'(pkt_valid), 32'd1);
        end else begin
            chk("drop_no_valid", 32'(pkt_valid), 32'd0);
            chk("drop_s_ready_stalls", 32'(stall_cnt - st0), 32'd0);
        end
    endtask

    task automatic check_counters(input string tag);
        repeat (3) @(negedge clock);
        chk({tag, "_good_cnt"}, 32'(good_cnt), 32'(sat(exp_good)));
        chk({tag, "_err_cnt"},  32'(err_cnt),  32'(sat(exp_err)));
    endtask

    task automatic load_scenario1();
        pay_buf[0] = 8'h01;
        pay_buf[1] = 8'h02;
        pay_buf[2] = 8'h03;
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_s_ready"},   32'(s_ready),     32'd0);
        chk({tag, "_pkt_valid"}, 32'(pkt_valid),   32'd0);
        chk({tag, "_good_cnt"},  32'(good_cnt),    32'd0);
        chk({tag, "_err_cnt"},   32'(err_cnt),     32'd0);
        chk({tag, "_header"},    32'(pkt_header),  32'd0);
        chk({tag, "_len"},       32'(pkt_len),     32'd0);
        chk({tag, "_payload"},   32'(|pkt_payload), 32'd0);
        chk({tag, "_crc_ok"},    32'(pkt_crc_ok),  32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int st0;
        int budget;
        int len_r;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_in_reset("reset");
        reset_n = 1'b1;
        #1;
        chk("reset_release_s_ready", 32'(s_ready), 32'd1);

        // Good packet A5 03 01 02 03 A6.
        load_scenario1();
        send_packet(8'hA5, 8'd3, 1'b0, 0, 1'b0);
        s_valid = 1'b0;
        check_counters("good_pkt");

        // Zero length, good crc then corrupted crc (3D).
        send_packet(8'h3C, 8'd0, 1'b0, 0, 1'b0);
        send_packet(8'h3C, 8'd0, 1'b1, 0, 1'b0);
        s_valid = 1'b0;
        check_counters("zero_len");

        // Oversize 0x14, then a good packet; also the longest oversize.
        send_packet(8'h11, 8'h14, 1'b0, 0, 1'b1);
        load_scenario1();
        send_packet(8'hA5, 8'd3, 1'b0, 0, 1'b0);
        send_packet(8'h22, 8'hFF, 1'b0, 0, 1'b1);
        load_scenario1();
        send_packet(8'hA5, 8'd3, 1'b0, 0, 1'b0);
        s_valid = 1'b0;
        check_counters("oversize");

        // Backpressure: record held for 10 cycles while another byte waits.
        ready_force = 1'b0;
        @(negedge clock);
        send_packet(8'h77, 8'd5, 1'b0, 0, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        exp_rec = exp_q[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_pkt_valid", 32'(pkt_valid), 32'd1);
            chk("bp_fields_stable",
                32'({pkt_header, pkt_len, pkt_crc_ok, pkt_payload} === exp_rec), 32'd1);
        end
        ready_force = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_release_valid", 32'(pkt_valid), 32'd0);
        chk("bp_release_s_ready", 32'(s_ready), 32'd1);
        send_packet(8'h5A, 8'd4, 1'b0, 0, 1'b1);
        s_valid = 1'b0;
        check_counters("backpressure");

        // Gapless back-to-back packets: one stall per packet boundary.
        st0 = stall_cnt;
        for (int p = 0; p < 6; p++) begin
            len_r = int'($urandom_range(1, MAX_LEN));
            send_packet(8'($urandom_range(0, 255)), 8'(len_r), 1'b0, 0, 1'b1);
        end
        s_valid = 1'b0;
        chk("throughput_stalls", 32'(stall_cnt - st0), 32'd5);
        check_counters("throughput");

        // Randomised stress: gaps, random backpressure, mixed packet kinds.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      len_r = int'($urandom_range(MAX_LEN + 1, 40));
            else if (kind == 1) len_r = 0;
            else                len_r = int'($urandom_range(1, MAX_LEN));
            send_packet(8'($urandom_range(0, 255)), 8'(len_r),
                        ($urandom_range(0, 3) == 0), 3, 1'b1);
        end
        s_valid    = 1'b0;
        rand_ready = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        chk("stress_drain", 32'(exp_q.size()), 32'd0);
        check_counters("stress");

        // Reset in the middle of a packet.
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        s_valid = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        exp_good = 0;
        exp_err  = 0;
        @(negedge clock);
        @(negedge clock);
        check_in_reset("mid_reset");
        reset_n = 1'b1;
        #1;
        chk("mid_reset_release_s_ready", 32'(s_ready), 32'd1);
        load_scenario1();
        send_packet(8'hA5, 8'd3, 1'b0, 0, 1'b0);
        s_valid = 1'b0;
        check_counters("after_reset");
        chk("after_reset_good_is_one", 32'(good_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
